// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone master controller:
//   - wb_state_e      : controller state encoding (IDLE / WDAT / BUS)
//   - WB_*_DEF        : default bus geometry and timeout
//   - RSP_*           : response codes, packed as {tmo, err}
//   - tmo_cnt_w()     : width of the timeout down-counter for a given TIMEOUT
// -----------------------------------------------------------------------------
package wb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WDAT = 2'd1,
      ST_BUS  = 2'd2
   } wb_state_e;

   localparam int WB_AW_DEF      = 5;
   localparam int WB_DW_DEF      = 32;
   localparam int WB_LW_DEF      = 4;
   localparam int WB_TIMEOUT_DEF = 16;

   // Response codes as {tmo, err}; a timeout is also an error.
   localparam logic [1:0] RSP_OK  = 2'b00;
   localparam logic [1:0] RSP_ERR = 2'b01;
   localparam logic [1:0] RSP_TMO = 2'b11;

   // The counter holds TIMEOUT-1 down to 0, so it needs clog2(TIMEOUT) bits
   // (at least one bit so the vector is never zero-width).
   function automatic int tmo_cnt_w(input int t);
      return (t < 2) ? 1 : $clog2(t);
   endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// wb_timeout_cnt
// Clearable, enable-gated down-counter used as the Wishbone ack watchdog.
// Clearing reloads TIMEOUT-1; each enabled cycle counts down towards 0.
// expire_o is high while enabled and the count has reached 0, i.e. on the
// TIMEOUT-th enabled cycle after the last clear. TIMEOUT=0 disables it.
//
// Ports:
//   clk_in    input   clock
//   rst_in    input   synchronous active-high reset (reloads the counter)
//   clr_in    input   reload the counter (beat entry / not on the bus)
//   en_in     input   count enable (strobe outstanding)
//   expire_o  output  timeout reached
// -----------------------------------------------------------------------------
module wb_timeout_cnt
   import wb_pkg::*;
#(
   parameter int TIMEOUT = WB_TIMEOUT_DEF,
   parameter int CW      = tmo_cnt_w(TIMEOUT)
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clr_in,
   input  logic en_in,
   output logic expire_o
);

   if (TIMEOUT == 0) begin : g_disabled
      logic unused_tmo;
      assign unused_tmo = ^{clk_in, rst_in, clr_in, en_in};
      assign expire_o   = 1'b0;
   end else begin : g_enabled
      localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);
      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk_in) begin
         if (rst_in || clr_in) begin
            cnt_q <= LOAD;
         end else if (en_in && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
         end
      end

      assign expire_o = en_in && (cnt_q == '0);
   end

endmodule

// File: rtl/wb_master_ctrl.sv
// -----------------------------------------------------------------------------
// wb_master_ctrl
// Command-driven Wishbone classic master. A command describes a block of
// cmd_len_in+1 beats at incrementing addresses (wrapping mod 2^AW). Write
// blocks fetch one data word per beat over the wdat handshake; every beat
// produces exactly one rsp_valid_o pulse. err_in or an ack timeout aborts
// the block with a final error response.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. Valid must not depend on ready; ready may depend on valid-free
// state only. Responses have no backpressure.
//
// Ports:
//   clk_in, rst_in                  clock, synchronous active-high reset
//   cmd_valid_in / cmd_ready_o      command handshake
//   cmd_we_in, cmd_adr_in,
//   cmd_sel_in, cmd_len_in          command fields (len = beats - 1)
//   wdat_valid_in / wdat_ready_o    per-beat write data handshake
//   wdat_in                         write beat data
//   rsp_valid_o, rsp_dat_o,
//   rsp_err_o, rsp_tmo_o, rsp_last_o  per-beat response pulse
//   adr_o, dat_o, sel_o, we_o,
//   cyc_o, stb_o                    registered Wishbone master outputs
//   dat_in, ack_in, err_in          Wishbone slave returns
//   state_o                         current controller state (debug)
// -----------------------------------------------------------------------------
module wb_master_ctrl
   import wb_pkg::*;
#(
   parameter int AW      = WB_AW_DEF,
   parameter int DW      = WB_DW_DEF,
   parameter int SW      = DW / 8,
   parameter int LW      = WB_LW_DEF,
   parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
   input  logic          clk_in,
   input  logic          rst_in,
   // command
   input  logic          cmd_valid_in,
   output logic          cmd_ready_o,
   input  logic          cmd_we_in,
   input  logic [AW-1:0] cmd_adr_in,
   input  logic [SW-1:0] cmd_sel_in,
   input  logic [LW-1:0] cmd_len_in,
   // write data
   input  logic          wdat_valid_in,
   output logic          wdat_ready_o,
   input  logic [DW-1:0] wdat_in,
   // response
   output logic          rsp_valid_o,
   output logic [DW-1:0] rsp_dat_o,
   output logic          rsp_err_o,
   output logic          rsp_tmo_o,
   output logic          rsp_last_o,
   // Wishbone master
   output logic [AW-1:0] adr_o,
   output logic [DW-1:0] dat_o,
   output logic [SW-1:0] sel_o,
   output logic          we_o,
   output logic          cyc_o,
   output logic          stb_o,
   input  logic [DW-1:0] dat_in,
   input  logic          ack_in,
   input  logic          err_in,
   // debug
   output wb_state_e     state_o
);

   wb_state_e     state_q, state_d;
   logic [LW-1:0] beat_q, beat_d;
   logic [LW-1:0] len_q, len_d;

   logic [AW-1:0] adr_d;
   logic [DW-1:0] dat_d;
   logic [SW-1:0] sel_d;
   logic          we_d, cyc_d, stb_d;

   logic          rsp_valid_d, rsp_last_d;
   logic [DW-1:0] rsp_dat_d;
   logic [1:0]    rsp_code_d;

   logic          last_beat;
   logic          tmo_expire;
   logic          tmo_clr;

   assign last_beat = (beat_q == len_q);

   // Reload on every beat entry: whenever not strobing, and on an ack that
   // keeps a read burst on the bus.
   assign tmo_clr = (state_q != ST_BUS) || ack_in;

   wb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .clr_in   (tmo_clr),
      .en_in    (state_q == ST_BUS),
      .expire_o (tmo_expire)
   );

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_in) begin
               state_d = cmd_we_in ? ST_WDAT : ST_BUS;
            end
         end
         ST_WDAT: begin
            if (wdat_valid_in) begin
               state_d = ST_BUS;
            end
         end
         ST_BUS: begin
            // err beats ack; ack beats a coincident timeout
            if (err_in) begin
               state_d = ST_IDLE;
            end else if (ack_in) begin
               if (last_beat) begin
                  state_d = ST_IDLE;
               end else if (we_o) begin
                  state_d = ST_WDAT;
               end
            end else if (tmo_expire) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // Computes the next value of every registered output; the handshake
   // readies are plain decodes of the current state.
   always_comb begin
      beat_d      = beat_q;
      len_d       = len_q;
      adr_d       = adr_o;
      dat_d       = dat_o;
      sel_d       = sel_o;
      we_d        = we_o;
      cyc_d       = cyc_o;
      stb_d       = stb_o;
      rsp_valid_d = 1'b0;
      rsp_last_d  = 1'b0;
      rsp_dat_d   = '0;
      rsp_code_d  = RSP_OK;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_in) begin
               beat_d = '0;
               len_d  = cmd_len_in;
               adr_d  = cmd_adr_in;
               sel_d  = cmd_sel_in;
               we_d   = cmd_we_in;
               cyc_d  = 1'b1;
               stb_d  = !cmd_we_in;
            end
         end
         ST_WDAT: begin
            if (wdat_valid_in) begin
               dat_d = wdat_in;
               stb_d = 1'b1;
            end
         end
         ST_BUS: begin
            if (err_in || ack_in || tmo_expire) begin
               rsp_valid_d = 1'b1;
            end
            if (err_in) begin
               rsp_code_d = RSP_ERR;
               rsp_last_d = 1'b1;
            end else if (ack_in) begin
               rsp_dat_d  = we_o ? '0 : dat_in;
               rsp_last_d = last_beat;
               if (!last_beat) begin
                  adr_d  = adr_o + AW'(1);
                  beat_d = beat_q + LW'(1);
                  stb_d  = !we_o;
               end
            end else if (tmo_expire) begin
               rsp_code_d = RSP_TMO;
               rsp_last_d = 1'b1;
            end
            // Block ends: release the bus, adr_o/dat_o keep their values.
            if (err_in || (ack_in && last_beat) || (!ack_in && tmo_expire)) begin
               cyc_d = 1'b0;
               stb_d = 1'b0;
               we_d  = 1'b0;
               sel_d = '0;
            end
         end
         default: begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            we_d  = 1'b0;
            sel_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         beat_q      <= '0;
         len_q       <= '0;
         adr_o       <= '0;
         dat_o       <= '0;
         sel_o       <= '0;
         we_o        <= 1'b0;
         cyc_o       <= 1'b0;
         stb_o       <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_dat_o   <= '0;
         rsp_err_o   <= 1'b0;
         rsp_tmo_o   <= 1'b0;
         rsp_last_o  <= 1'b0;
      end else begin
         beat_q      <= beat_d;
         len_q       <= len_d;
         adr_o       <= adr_d;
         dat_o       <= dat_d;
         sel_o       <= sel_d;
         we_o        <= we_d;
         cyc_o       <= cyc_d;
         stb_o       <= stb_d;
         rsp_valid_o <= rsp_valid_d;
         rsp_dat_o   <= rsp_dat_d;
         rsp_err_o   <= rsp_code_d[0];
         rsp_tmo_o   <= rsp_code_d[1];
         rsp_last_o  <= rsp_last_d;
      end
   end

   assign cmd_ready_o  = (state_q == ST_IDLE);
   assign wdat_ready_o = (state_q == ST_WDAT);
   assign state_o      = state_q;

endmodule
